pll_reset_sequencer: RTL



---
 rtl/pll_reset_sequencer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: supervises the mf_pllbase PLL from the 74.25 MHz
// reference clock. Pulses the PLL reset, waits for a synchronized lock,
// qualifies lock stability and only then releases the core reset. A lock
// loss in RUN re-asserts the core reset and restarts the PLL sequence; lock
// timeouts retry automatically and raise a sticky fail flag after
// MAX_RETRIES.
//
// Optional build macro: PLL_RESET_SEQUENCER_LOCK_LOSS_COUNT_EN
//   defined   -> lock_loss_count counts RUN->PLL_RST transitions caused by
//                lock loss (saturating at 255, cleared only by rst)
//   undefined -> lock_loss_count is tied to zero
module pll_reset_sequencer #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 74250,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       reinit,
    output logic       pll_rst,
    output logic       core_rst,
    output logic       ready,
    output logic       fail,
    output logic [7:0] retry_count,
    output logic [7:0] lock_loss_count
);

    // Shared counter sized for the longest of the three windows.
    localparam int unsigned MAX_AB = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned MAX_CNT = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int unsigned CW = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic          timeout;

    logic          sync0;
    logic          lk;

    logic          pll_rst_d;
    logic          core_rst_d;
    logic          ready_d;
    logic          fail_d;
    logic [7:0]    retry_d;

    // Two-flop synchronizer bringing the asynchronous PLL lock into clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync0 <= 1'b0;
            lk    <= 1'b0;
        end else begin
            sync0 <= pll_locked;
            lk    <= sync0;
        end
    end

    // State, shared counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_PLL_RST;
            cnt         <= '0;
            pll_rst     <= 1'b1;
            core_rst    <= 1'b1;
            ready       <= 1'b0;
            fail        <= 1'b0;
            retry_count <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            pll_rst     <= pll_rst_d;
            core_rst    <= core_rst_d;
            ready       <= ready_d;
            fail        <= fail_d;
            retry_count <= retry_d;
        end
    end

    // Next-state and counter decode; reinit overrides every other transition.
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        timeout = 1'b0;
        if (reinit) begin
            state_n = S_PLL_RST;
            cnt_n   = '0;
        end else begin
            case (state)
                S_PLL_RST: begin
                    if (cnt == RST_LAST) begin
                        state_n = S_WAIT_LOCK;
                        cnt_n   = '0;
                    end
                end
                S_WAIT_LOCK: begin
                    // Lock seen in the timeout cycle still wins.
                    if (lk) begin
                        state_n = S_STABLE;
                        cnt_n   = '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        timeout = 1'b1;
                        state_n = S_PLL_RST;
                        cnt_n   = '0;
                    end
                end
                S_STABLE: begin
                    if (!lk) begin
                        state_n = S_WAIT_LOCK;
                        cnt_n   = '0;
                    end else if (cnt == STABLE_LAST) begin
                        state_n = S_RUN;
                        cnt_n   = '0;
                    end
                end
                S_RUN: begin
                    // Counter is parked in RUN so it never wraps there.
                    cnt_n = '0;
                    if (!lk) begin
                        state_n = S_PLL_RST;
                    end
                end
                default: begin
                    state_n = S_PLL_RST;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // Output decode from the next state, plus retry/fail bookkeeping.
    always_comb begin
        pll_rst_d  = (state_n == S_PLL_RST);
        core_rst_d = (state_n != S_RUN);
        ready_d    = (state_n == S_RUN);
        retry_d    = retry_count;
        fail_d     = fail;
        if (reinit) begin
            retry_d = '0;
            fail_d  = 1'b0;
        end else if (timeout) begin
            if (retry_count != 8'hFF) begin
                retry_d = retry_count + 8'd1;
            end
            if (32'(retry_count) >= MAX_RETRIES) begin
                fail_d = 1'b1;
            end
        end
    end

`ifdef PLL_RESET_SEQUENCER_LOCK_LOSS_COUNT_EN
    logic       lock_loss_evt;
    logic [7:0] lock_loss_q;

    assign lock_loss_evt = (state == S_RUN) && !lk && !reinit;

    // Saturating count of lock losses seen while running; only rst clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_loss_q <= '0;
        end else if (lock_loss_evt && (lock_loss_q != 8'hFF)) begin
            lock_loss_q <= lock_loss_q + 8'd1;
        end
    end

    assign lock_loss_count = lock_loss_q;
`else
    assign lock_loss_count = '0;
`endif

endmodule
